pulse_monitor: RTL and testbench

//  Downstream consumer of the pulse generator output. Measures high width and period of a

---
 rtl/pulse_monitor_pkg.sv | 12 +
 rtl/pulse_monitor_if.sv | 22 ++
 rtl/pulse_monitor_edge_detect.sv | 23 ++
 rtl/pulse_monitor.sv | 113 +++++++++++
 tb/tb_pulse_monitor.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pulse_monitor_pkg.sv
// Shared types and defaults for the pulse monitor: FSM state encoding and default counter width.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pm_state_t;

  localparam int PM_CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pulse_monitor_if.sv
// Pulse monitor bus: control/stimulus inputs plus measurement outputs.
interface pulse_monitor_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             pulse_in;
  logic [CNT_W-1:0] width_out;
  logic [CNT_W-1:0] period_out;
  logic             meas_valid;
  logic [CNT_W-1:0] pulse_count;
  logic             timeout;

  modport master (
    output enable, pulse_in,
    input  width_out, period_out, meas_valid, pulse_count, timeout
  );

  modport slave (
    input  enable, pulse_in,
    output width_out, period_out, meas_valid, pulse_count, timeout
  );
endinterface

// File: rtl/pulse_monitor_edge_detect.sv
// One-cycle-delay edge detector; the reset value of the history bit is a parameter so a
// level already high when reset releases is not mistaken for a rising edge.
module edge_detect #(
  parameter logic PREV_RST = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= PREV_RST;
    else       r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;
  assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/pulse_monitor.sv
// Measures high width and rise-to-rise period of a same-clock pulse train, strobes each
// completed measurement, counts measurements and flags loss of pulses.
module pulse_monitor
  import pulse_pkg::*;
#(
  parameter int CNT_W   = PM_CNT_W_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  pulse_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  pm_state_t        r_state, w_next;
  logic [CNT_W-1:0] r_width_cnt, r_period_cnt;
  logic [CNT_W-1:0] w_width_nxt, w_period_nxt;
  logic [CNT_W-1:0] r_width_out, r_period_out, r_pulse_count;
  logic             r_meas_valid, r_timeout;
  logic             w_meas, w_tmo_nxt;
  logic             w_rise, w_fall;

  edge_detect #(
    .PREV_RST(1'b1)
  ) u_edge (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_sig  (bus.pulse_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_next       = r_state;
    w_width_nxt  = r_width_cnt;
    w_period_nxt = r_period_cnt;
    w_meas       = 1'b0;
    w_tmo_nxt    = r_timeout;
    if (!bus.enable) begin
      w_next       = IDLE;
      w_width_nxt  = '0;
      w_period_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // First rise only arms the monitor; there is no previous pulse to report.
          if (w_rise) begin
            w_next       = HIGH;
            w_width_nxt  = ONE;
            w_period_nxt = ONE;
            w_tmo_nxt    = 1'b0;
          end
        end
        HIGH, LOW: begin
          if (w_rise) begin
            w_meas       = 1'b1;
            w_next       = HIGH;
            w_width_nxt  = ONE;
            w_period_nxt = ONE;
            w_tmo_nxt    = 1'b0;
          end else if (r_period_cnt == TMO_LIM) begin
            w_next       = IDLE;
            w_width_nxt  = '0;
            w_period_nxt = '0;
            w_tmo_nxt    = 1'b1;
          end else begin
            w_period_nxt = r_period_cnt + ONE;
            if (r_state == HIGH && bus.pulse_in) w_width_nxt = r_width_cnt + ONE;
            if (r_state == HIGH && w_fall)       w_next      = LOW;
          end
        end
        default: begin
          w_next       = IDLE;
          w_width_nxt  = '0;
          w_period_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_width_cnt   <= '0;
      r_period_cnt  <= '0;
      r_width_out   <= '0;
      r_period_out  <= '0;
      r_pulse_count <= '0;
      r_meas_valid  <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_width_cnt  <= w_width_nxt;
      r_period_cnt <= w_period_nxt;
      r_meas_valid <= w_meas;
      r_timeout    <= w_tmo_nxt;
      if (w_meas) begin
        r_width_out   <= r_width_cnt;
        r_period_out  <= r_period_cnt;
        r_pulse_count <= r_pulse_count + ONE;
      end
    end
  end

  assign bus.width_out   = r_width_out;
  assign bus.period_out  = r_period_out;
  assign bus.meas_valid  = r_meas_valid;
  assign bus.pulse_count = r_pulse_count;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_pulse_monitor.sv
// Scoreboard bench for pulse_monitor: expected measurements are queued when each rise is
// driven and compared when the strobe appears; timeout set/clear cycles are tracked too.
module tb_pulse_monitor;

  localparam int CNT_W = 32;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pulse_monitor_if #(.CNT_W(CNT_W)) bus();

  pulse_monitor #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int w;
    int p;
    int n;
    int c;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  bit m_armed = 1'b0;
  bit m_tmo_pending = 1'b0;
  int m_hi = 0;
  int m_lo = 0;
  int m_cnt = 0;
  int tmo_set_cyc = -10;
  int clr_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one pulse: rise, hi cycles high in total, then lo cycles low. Optionally drops
  // enable for dis_len low cycles starting at low index dis_at.
  task automatic pulse(input int hi, input int lo, input int dis_at = -1, input int dis_len = 0);
    tick();
    bus.pulse_in = 1'b1;
    bus.enable   = 1'b1;
    if (m_armed) begin
      m_cnt++;
      sb.push_back('{m_hi, m_hi + m_lo, m_cnt, cyc + 1});
    end
    if (m_tmo_pending) begin
      clr_cyc       = cyc + 1;
      m_tmo_pending = 1'b0;
    end
    m_armed = 1'b1;
    m_hi    = hi;
    m_lo    = lo;
    if (hi + lo > TMO) begin
      m_armed       = 1'b0;
      m_tmo_pending = 1'b1;
      tmo_set_cyc   = cyc + TMO + 1;
    end
    for (int i = 1; i < hi; i++) tick();
    for (int i = 0; i < lo; i++) begin
      tick();
      bus.pulse_in = 1'b0;
      bus.enable   = !(i >= dis_at && i < dis_at + dis_len);
    end
    if (dis_len > 0) m_armed = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.meas_valid) begin
        if (sb.size() == 0) begin
          check_val("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("width_out",   bus.width_out,   e.w);
          check_val("period_out",  bus.period_out,  e.p);
          check_val("pulse_count", bus.pulse_count, e.n);
          check_val("strobe_cycle", cyc, e.c);
        end
      end
      if (cyc == tmo_set_cyc - 1) check_val("timeout_early", bus.timeout, 1'b0);
      if (cyc == tmo_set_cyc)     check_val("timeout_set",   bus.timeout, 1'b1);
      if (cyc == clr_cyc)         check_val("timeout_clear", bus.timeout, 1'b0);
    end
  end

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.pulse_in = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_val("rst_width",   bus.width_out,   0);
    check_val("rst_period",  bus.period_out,  0);
    check_val("rst_count",   bus.pulse_count, 0);
    check_val("rst_valid",   bus.meas_valid,  0);
    check_val("rst_timeout", bus.timeout,     0);

    // Release reset with the input already high: no arm until a fall and a fresh rise.
    tick();
    reset = 1'b0;
    repeat (3) tick();
    bus.pulse_in = 1'b0;
    repeat (4) tick();

    repeat (7) pulse(2, 8);
    pulse(1, 1);
    pulse(3, 4);
    pulse(2, 14);
    pulse(3, 14);
    pulse(2, 8);
    pulse(20, 3);
    pulse(2, 8);
    pulse(2, 8);

    pulse(2, 8, 3, 3);
    pulse(2, 8);
    pulse(2, 8);
    pulse(2, 8);

    repeat (5) pulse(2, 5);
    pulse(4, 0);
    tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_width",   bus.width_out,   0);
    check_val("mid_rst_period",  bus.period_out,  0);
    check_val("mid_rst_count",   bus.pulse_count, 0);
    check_val("mid_rst_valid",   bus.meas_valid,  0);
    check_val("mid_rst_timeout", bus.timeout,     0);
    check_val("sb_drained_before_rst", sb.size(), 0);
    m_armed = 1'b0;
    m_cnt   = 0;
    tick();
    reset        = 1'b0;
    bus.pulse_in = 1'b0;
    repeat (3) tick();
    pulse(3, 6);
    pulse(3, 6);
    pulse(2, 4);

    repeat (4) tick();
    check_val("sb_empty", sb.size(), 0);
    check_val("final_count", bus.pulse_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
